// File: rtl/clkgen_pkg.sv
// Shared types and defaults for the multi-phase clock generator.
// The STALLED state is only reachable when CLKGEN_STALL_EN is defined.
package clkgen_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2
    } clkgen_state_e;

    localparam int DEF_PERIOD         = 4;
    localparam int DEF_PC_PHASE       = 0;
    localparam int DEF_IMEM_PHASE     = 1;
    localparam int DEF_DMEM_PHASE     = 3;
    localparam int DEF_RF_PHASE       = 0;
    localparam int DEF_WARMUP_PERIODS = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int ph_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_pulse.sv
// One generated clock: high for the half period starting at OFFSET.
// Driven from the next-cycle phase so the flop output lines up with ph.
module phase_pulse
    import clkgen_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int OFFSET = 0,
    parameter int PH_W   = ph_width(DEF_PERIOD)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PH_W-1:0] ph,
    input  logic            enable,
    output logic            pulse
);

    function automatic logic in_high(logic [PH_W-1:0] p);
        int d;
        d = int'(p) - OFFSET;
        if (d < 0) d = d + PERIOD;
        return (d < PERIOD / 2);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= enable && in_high(ph);
        end
    end

endmodule

// File: rtl/multi_phase_clock_gen.sv
// Multi-phase clock generator: four phase-offset clocks derived from one master clock.
// Define CLKGEN_STALL_EN to add stall_req/step/stalled single-step debug support.
module multi_phase_clock_gen
    import clkgen_pkg::*;
#(
    parameter int PERIOD         = DEF_PERIOD,
    parameter int PC_PHASE       = DEF_PC_PHASE,
    parameter int IMEM_PHASE     = DEF_IMEM_PHASE,
    parameter int DMEM_PHASE     = DEF_DMEM_PHASE,
    parameter int RF_PHASE       = DEF_RF_PHASE,
    parameter int WARMUP_PERIODS = DEF_WARMUP_PERIODS
) (
    input  logic clock,
    input  logic reset,
`ifdef CLKGEN_STALL_EN
    input  logic stall_req,
    input  logic step,
    output logic stalled,
`endif
    output logic processor_clock,
    output logic imem_clock,
    output logic dmem_clock,
    output logic regfile_clock,
    output logic clocks_valid,
    output logic period_tick
);

    localparam int PH_W = ph_width(PERIOD);
    localparam int WU_W = ph_width(WARMUP_PERIODS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP_PERIODS - 1);

    if (PERIOD < 2 || (PERIOD % 2) != 0) begin : g_chk_period
        $error("multi_phase_clock_gen: PERIOD must be even and >= 2");
    end
    if (PC_PHASE < 0 || PC_PHASE >= PERIOD || IMEM_PHASE < 0 || IMEM_PHASE >= PERIOD ||
        DMEM_PHASE < 0 || DMEM_PHASE >= PERIOD || RF_PHASE < 0 || RF_PHASE >= PERIOD) begin : g_chk_phase
        $error("multi_phase_clock_gen: every phase offset must lie in 0..PERIOD-1");
    end
    if (WARMUP_PERIODS < 1) begin : g_chk_warmup
        $error("multi_phase_clock_gen: WARMUP_PERIODS must be >= 1");
    end

    clkgen_state_e   state, state_nxt;
    logic [PH_W-1:0] ph, ph_nxt;
    logic [WU_W-1:0] warm_cnt, warm_cnt_nxt;
    logic            wrap;
    logic            en_core, en_mem, tick_nxt;
`ifdef CLKGEN_STALL_EN
    logic            stalled_nxt;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= WARMUP;
            ph       <= '0;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ph       <= ph_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    // Next-state logic; every state change happens on the PERIOD-1 -> 0 wrap
    always_comb begin
        wrap         = (ph == PH_LAST);
        ph_nxt       = wrap ? '0 : ph + 1'b1;
        warm_cnt_nxt = warm_cnt;
        state_nxt    = state;
        case (state)
            WARMUP: begin
                if (wrap) begin
                    if (warm_cnt == WU_LAST) state_nxt = RUN;
                    else                     warm_cnt_nxt = warm_cnt + 1'b1;
                end
            end
            RUN: begin
`ifdef CLKGEN_STALL_EN
                if (wrap && stall_req) state_nxt = STALLED;
`endif
            end
            STALLED: begin
`ifdef CLKGEN_STALL_EN
                if (wrap && (!stall_req || step)) state_nxt = RUN;
`else
                state_nxt = WARMUP;
`endif
            end
            default: state_nxt = WARMUP;
        endcase
    end

    // Output decode from the next state, so registered outputs align with ph
    always_comb begin
        en_core  = (state_nxt == RUN);
        en_mem   = (state_nxt == RUN) || (state_nxt == STALLED);
        tick_nxt = en_core && (ph_nxt == PH_LAST);
`ifdef CLKGEN_STALL_EN
        stalled_nxt = (state_nxt == STALLED);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clocks_valid <= 1'b0;
            period_tick  <= 1'b0;
`ifdef CLKGEN_STALL_EN
            stalled      <= 1'b0;
`endif
        end else begin
            clocks_valid <= en_mem;
            period_tick  <= tick_nxt;
`ifdef CLKGEN_STALL_EN
            stalled      <= stalled_nxt;
`endif
        end
    end

    phase_pulse #(.PERIOD(PERIOD), .OFFSET(PC_PHASE), .PH_W(PH_W)) u_pc (
        .clock(clock), .reset(reset), .ph(ph_nxt), .enable(en_core), .pulse(processor_clock)
    );
    phase_pulse #(.PERIOD(PERIOD), .OFFSET(IMEM_PHASE), .PH_W(PH_W)) u_imem (
        .clock(clock), .reset(reset), .ph(ph_nxt), .enable(en_mem), .pulse(imem_clock)
    );
    phase_pulse #(.PERIOD(PERIOD), .OFFSET(DMEM_PHASE), .PH_W(PH_W)) u_dmem (
        .clock(clock), .reset(reset), .ph(ph_nxt), .enable(en_mem), .pulse(dmem_clock)
    );
    phase_pulse #(.PERIOD(PERIOD), .OFFSET(RF_PHASE), .PH_W(PH_W)) u_rf (
        .clock(clock), .reset(reset), .ph(ph_nxt), .enable(en_core), .pulse(regfile_clock)
    );

endmodule
